// File: rtl/csconvert_raw_tile_if.sv
// csconvert_raw_tile_if: raw pixel stream in, signed tile-buffer write port out
interface csconvert_raw_tile_if #(parameter int DW = 8, parameter int TW_LOG2 = 4);
  logic en;
  logic [1:0] mode;
  logic scale_diff;
  logic hdr;
  logic [1:0] bayer_phase;
  logic pre_first_in;
  logic [DW-1:0] din;
  logic [DW:0] y_out;
  logic [2*TW_LOG2-1:0] yaddr;
  logic ywe;
  logic pre_first_out;
  logic busy;
  modport master (
    output en, mode, scale_diff, hdr, bayer_phase, pre_first_in, din,
    input y_out, yaddr, ywe, pre_first_out, busy
  );
  modport slave (
    input en, mode, scale_diff, hdr, bayer_phase, pre_first_in, din,
    output y_out, yaddr, ywe, pre_first_out, busy
  );
endinterface

// File: rtl/csconvert_raw_tile.sv
// csconvert_raw_tile: mono / jp4 / jp4diff raw tile converter feeding the compressor tile buffer
module csconvert_raw_tile #(
  parameter int DW = 8,
  parameter int TW_LOG2 = 4
) (
  input logic clk,
  input logic rst,
  csconvert_raw_tile_if.slave s
);
  localparam int TW = 1 << TW_LOG2;
  localparam int AW = 2 * TW_LOG2;
  localparam logic [AW-1:0] LAST = AW'(TW * TW - 1);
  localparam logic [DW:0] B = {2'b01, {(DW-1){1'b0}}};
  logic w_act, w_start, w_ds, w_df, w_jp, w_odf_n, w_kr, w_kc, w_isabs;
  logic [1:0] w_p;
  logic [DW-1:0] w_pix, w_ref;
  logic [DW:0] w_m, w_abs, w_dif, w_dv;
  logic [TW+4:0] r_sdl;
  logic [TW:0][DW-1:0] r_dl;
  logic [1:0] r_mode, r_ph;
  logic r_sc, r_hdr, r_pend, r_ywe, r_ojp, r_odf;
  logic [TW_LOG2:0] r_j;
  logic [AW-1:0] r_c;
  logic [DW:0] r_d1, r_d2, r_d3, r_y;
  assign w_act = s.en & ~rst;
  assign w_start = s.pre_first_in & s.en;
  assign w_df = r_mode == 2'd2;
  assign w_jp = r_mode == 2'd1 || w_df;
  // jp4diff waits D+3 so the reference pixel of every cell is already in the delay line
  assign w_ds = !w_df ? r_sdl[0] :
                r_ph[1] ? (r_ph[0] ? r_sdl[TW+4] : r_sdl[TW+3]) : (r_ph[0] ? r_sdl[4] : r_sdl[3]);
  assign w_odf_n = w_ds ? w_df : r_odf;
  // Cell position of pixel k = j - D, the one D samples behind the newest
  assign w_kc = r_j[0] ^ r_ph[0];
  assign w_kr = r_j[TW_LOG2] ^ r_ph[1] ^ (r_ph[0] & ~|r_j[TW_LOG2-1:0]);
  assign w_p = {w_kr, w_kc};
  assign w_pix = r_ph[1] ? (r_ph[0] ? r_dl[TW] : r_dl[TW-1]) : (r_ph[0] ? r_dl[0] : s.din);
  assign w_ref = w_p[1] ? (w_p[0] ? r_dl[TW] : r_dl[TW-1]) : (w_p[0] ? r_dl[0] : s.din);
  assign w_m = {1'b0, s.din} - B;
  assign w_abs = {1'b0, w_pix} - B;
  assign w_dif = {1'b0, w_pix} - {1'b0, w_ref};
  assign w_isabs = w_p == r_ph || (r_hdr && w_p == ~r_ph);
  assign w_dv = w_isabs ? w_abs : r_sc ? {w_dif[DW], w_dif[DW:1]} : w_dif;
  assign s.y_out = w_act ? r_y : '0;
  assign s.yaddr = !w_act ? '0 :
                   r_ojp ? {r_c[TW_LOG2], r_c[AW-1:TW_LOG2+1], r_c[0], r_c[TW_LOG2-1:1]} : r_c;
  assign s.ywe = w_act & r_ywe;
  assign s.pre_first_out = w_act & w_ds;
  assign s.busy = w_act & (r_pend | r_ywe);
  always_ff @(posedge clk) begin
    if (rst || !s.en) begin
      r_sdl <= '0;
      r_dl <= '0;
      r_j <= '0;
      r_mode <= '0;
      r_ph <= '0;
      r_sc <= 1'b0;
      r_hdr <= 1'b0;
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
      r_y <= '0;
      r_pend <= 1'b0;
      r_c <= '0;
      r_ywe <= 1'b0;
      r_ojp <= 1'b0;
      r_odf <= 1'b0;
    end else begin
      r_sdl <= {r_sdl[TW+3:0], w_start};
      r_dl <= {r_dl[TW-1:0], s.din};
      r_j <= w_start ? '0 : r_j + 1'b1;
      if (w_start) begin
        r_mode <= s.mode;
        r_ph <= s.bayer_phase;
        r_sc <= s.scale_diff;
        r_hdr <= s.hdr;
      end
      r_d1 <= w_dv;
      r_d2 <= r_d1;
      r_d3 <= r_d2;
      r_y <= w_odf_n ? r_d3 : w_m;
      r_pend <= w_start | (r_pend & ~w_ds);
      if (w_ds) begin
        r_c <= '0;
        r_ywe <= 1'b1;
        r_ojp <= w_jp;
        r_odf <= w_df;
      end else if (r_ywe) begin
        r_c <= r_c + 1'b1;
        r_ywe <= r_c != LAST;
      end
    end
  end
endmodule

// File: tb/tb_csconvert_raw_tile.sv
// tb_csconvert_raw_tile: scoreboard bench for csconvert_raw_tile
module tb_csconvert_raw_tile;
  localparam int DW = 8, TW_LOG2 = 4, TW = 16, N = 256;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  csconvert_raw_tile_if #(.DW(DW), .TW_LOG2(TW_LOG2)) s();
  csconvert_raw_tile #(.DW(DW), .TW_LOG2(TW_LOG2)) dut (.clk(clk), .rst(rst), .s(s));
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_chk = 0, n_fail = 0;
  int sbq[$];
  logic [7:0] pix [2][N];
  logic [1:0] tm [2], tr [2];
  logic th [2], ts [2];
  int t0, first_ywe, first_pfo, nwr, run, maxrun, busy_fall;
  bit prev_busy = 1'b0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int exp_word(input int i, input int k);
    int row, col, pr, pc, p, r, v, rf, addr;
    row = k / TW; col = k % TW; pr = row % 2; pc = col % 2; p = pr * 2 + pc; r = int'(tr[i]);
    addr = (tm[i] == 2'd1 || tm[i] == 2'd2) ?
           ((pr << (2*TW_LOG2-1)) | ((row >> 1) << TW_LOG2) | (pc << (TW_LOG2-1)) | (col >> 1)) : k;
    if (tm[i] != 2'd2 || p == r || (th[i] && p == (r ^ 3))) v = int'(pix[i][k]) - 128;
    else begin
      rf = int'(pix[i][((row & ~1) + (r >> 1)) * TW + (col & ~1) + (r & 1)]);
      v = int'(pix[i][k]) - rf;
      if (ts[i]) v = v >>> 1;
    end
    return (addr << 9) | (v & 'h1FF);
  endfunction
  always @(negedge clk) begin
    if (s.ywe === 1'b1) begin
      if (sbq.size() == 0) check("unexpected_ywe", 1, 0);
      else check("wr_addr_data", {15'b0, s.yaddr, s.y_out}, sbq.pop_front());
      nwr++; run++;
      if (first_ywe < 0) first_ywe = cyc;
    end else run = 0;
    if (run > maxrun) maxrun = run;
    if (s.pre_first_out === 1'b1 && first_pfo < 0) first_pfo = cyc;
    if (prev_busy && s.busy !== 1'b1 && busy_fall < 0) busy_fall = cyc;
    prev_busy = s.busy === 1'b1;
  end
  task automatic set_ctx(input int i, input int m, input int r, input int h, input int sc);
    tm[i] = 2'(m); tr[i] = 2'(r); th[i] = h[0]; ts[i] = sc[0];
  endtask
  task automatic fill_ramp(input int i);
    for (int k = 0; k < N; k++) pix[i][k] = 8'(k);
  endtask
  task automatic fill_rand(input int i);
    for (int k = 0; k < N; k++) pix[i][k] = 8'($urandom);
  endtask
  task automatic fill_cell(input int i, input int a, input int b, input int c, input int d);
    int p;
    for (int k = 0; k < N; k++) begin
      p = ((k / TW) % 2) * 2 + k % 2;
      pix[i][k] = 8'(p == 0 ? a : p == 1 ? b : p == 2 ? c : d);
    end
  endtask
  task automatic push_tile(input int i, input int nk);
    for (int k = 0; k < nk; k++) sbq.push_back(exp_word(i, k));
  endtask
  task automatic stream(input int nt, input int abort_c, input bit abort_rst);
    first_ywe = -1; first_pfo = -1; nwr = 0; maxrun = 0; busy_fall = -1;
    for (int c = 0; c <= nt * N; c++) begin
      @(posedge clk); #1;
      if (c == 0) t0 = cyc;
      s.pre_first_in = (c % N == 0) && (c / N < nt);
      if (c / N < nt) begin
        s.mode = tm[c/N]; s.bayer_phase = tr[c/N]; s.hdr = th[c/N]; s.scale_diff = ts[c/N];
      end
      s.din = c > 0 ? pix[(c-1)/N][(c-1)%N] : 8'h00;
      if (c == abort_c) begin
        if (abort_rst) rst = 1'b1; else s.en = 1'b0;
        @(negedge clk);
        check("abort_ywe", s.ywe, 0); check("abort_yaddr", s.yaddr, 0);
        check("abort_busy", s.busy, 0); check("abort_y", s.y_out, 0);
        @(posedge clk); #1;
        rst = 1'b0; s.en = 1'b1; s.pre_first_in = 1'b0;
        @(negedge clk);
        check("post_abort_ywe", s.ywe, 0); check("post_abort_busy", s.busy, 0);
        return;
      end
    end
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      if (s.busy !== 1'b1 && sbq.size() == 0) break;
    end
    check("idle_busy", s.busy, 0);
    check("drain", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    s.en = 1'b1; s.pre_first_in = 1'b0; s.din = '0; s.mode = '0;
    s.bayer_phase = '0; s.hdr = 1'b0; s.scale_diff = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ywe", s.ywe, 0); check("rst_yaddr", s.yaddr, 0); check("rst_y", s.y_out, 0);
    check("rst_busy", s.busy, 0); check("rst_pfo", s.pre_first_out, 0);
    @(posedge clk); #1 rst = 1'b0;
    fill_ramp(0); set_ctx(0, 0, 0, 0, 0); push_tile(0, N); stream(1, -1, 0); wait_idle();
    check("mono_pfo", first_pfo - t0, 1); check("mono_lat", first_ywe - t0, 2);
    check("mono_n", nwr, N); check("mono_busy_fall", busy_fall - t0, 258);
    set_ctx(0, 1, 0, 0, 0); push_tile(0, N); stream(1, -1, 0); wait_idle();
    check("jp4_lat", first_ywe - t0, 2); check("jp4_n", nwr, N);
    fill_cell(0, 100, 120, 90, 110);
    for (int v = 0; v < 3; v++) begin
      set_ctx(0, 2, 0, v == 1, v == 2); push_tile(0, N); stream(1, -1, 0); wait_idle();
      check("diff_r0_lat", first_ywe - t0, 5);
    end
    fill_rand(0); set_ctx(0, 2, 3, 0, 0); push_tile(0, N); stream(1, -1, 0); wait_idle();
    check("r3_pfo", first_pfo - t0, 21); check("r3_lat", first_ywe - t0, 22);
    check("r3_n", nwr, N); check("r3_busy_fall", busy_fall - t0, 278);
    for (int t = 0; t < 3; t++) begin
      fill_rand(0);
      set_ctx(0, t == 2 ? 3 : 2, t == 2 ? 0 : t + 1, $urandom % 2, $urandom % 2);
      push_tile(0, N); stream(1, -1, 0); wait_idle();
      check("rand_n", nwr, N);
    end
    for (int v = 0; v < 4; v++) begin
      if (v < 2) fill_cell(0, 0, 255, 255, 255); else fill_cell(0, 255, 0, 0, 0);
      set_ctx(0, 2, 0, 0, v % 2); push_tile(0, N); stream(1, -1, 0); wait_idle();
    end
    fill_ramp(0); set_ctx(0, 0, 0, 0, 0); push_tile(0, 99); stream(1, 101, 0); wait_idle();
    check("en_abort_n", nwr, 99);
    push_tile(0, 99); stream(1, 101, 1); wait_idle();
    check("rst_abort_n", nwr, 99);
    @(posedge clk); #1 s.en = 1'b0; s.pre_first_in = 1'b1;
    @(posedge clk); #1 s.en = 1'b1; s.pre_first_in = 1'b0;
    nwr = 0;
    repeat (30) @(negedge clk);
    check("ign_busy", s.busy, 0); check("ign_nwr", nwr, 0);
    fill_ramp(0); fill_rand(1); set_ctx(0, 1, 0, 0, 0); set_ctx(1, 1, 0, 0, 0);
    push_tile(0, N); push_tile(1, N); stream(2, -1, 0); wait_idle();
    check("b2b_jp4_run", maxrun, 2 * N);
    fill_rand(0); set_ctx(0, 2, 1, 1, 1); set_ctx(1, 2, 1, 1, 1);
    push_tile(0, N); push_tile(1, N); stream(2, -1, 0); wait_idle();
    check("b2b_diff_run", maxrun, 2 * N);
    fill_rand(0); fill_rand(1); set_ctx(0, 2, 3, 0, 0); set_ctx(1, 0, 0, 0, 0);
    push_tile(0, N - 20); push_tile(1, N); stream(2, -1, 0); wait_idle();
    check("trunc_n", nwr, 2 * N - 20); check("trunc_run", maxrun, 2 * N - 20);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/csconvert_raw_tile.md
Name: csconvert_raw_tile

Overview:
Parametrised raw-pixel tile converter for the compressor front end. It accepts a continuous scanline-ordered TW x TW tile stream and emits signed tile samples plus write addresses for the compressor's tile buffer. It supports three run-time modes: mono, JP4 (Bayer-plane reordered) and JP4-diff (colour differences against a selected Bayer reference). Pixel width and tile size are generic, and consecutive tiles may be pipelined back-to-back.

Parameters:
DW, 8, input pixel width in bits (8..12); output width is DW+1
TW_LOG2, 4, log2 of tile side; TW=2^TW_LOG2, N=TW*TW pixels per tile, AW=2*TW_LOG2

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  block enable; low = abort and hold idle
mode  in  2  0 mono, 1 jp4, 2 jp4diff, 3 treated as mono; latched at start
scale_diff  in  1  jp4diff: arithmetic shift right 1 of difference samples; latched at start
hdr  in  1  jp4diff: second green (R^3) absolute, not difference; latched at start
bayer_phase  in  2  jp4diff reference position R in 2x2 cell {row[0],col[0]}; latched at start
pre_first_in  in  1  pulse one cycle before first pixel of a tile (cycle t0)
din  in  DW  pixel k of tile on din at cycle t0+1+k, k=0..N-1, every cycle
y_out  out  DW+1  signed two's-complement output sample
yaddr  out  AW  tile-buffer write address
ywe  out  1  write strobe; y_out/yaddr valid when high
pre_first_out  out  1  pulse one cycle before first ywe of a tile
busy  out  1  high from latched start until last ywe of tile

Behaviour:
- Reset (rst=1) or en=0: y_out=0, yaddr=0, ywe=0, pre_first_out=0, busy=0. Delay lines and counters are cleared and any in-flight tile is dropped; the rst/en-low cycle itself produces no write.
- Start: pre_first_in with en=1 latches mode, bayer_phase, scale_diff and hdr into a per-tile context.
- The start is delayed by S cycles before reaching the output sequencer:
  - mono/jp4: S=0.
  - jp4diff: S=D+3, with D={0,1,TW,TW+1} for R=0..3.
- Output sequencer:
  - AW-bit counter c cleared on the delayed start, increments while ywe.
  - ywe is high for exactly N cycles, starting one cycle after the delayed start.
  - pre_first_out is registered and coincides with the delayed start.
  - busy rises at pre_first_in and falls after the last ywe.
- Latency: first ywe at t0+2 (mono/jp4) or t0+D+5 (jp4diff).
- Addressing:
  - mono: yaddr=c.
  - jp4/jp4diff: with row=c[AW-1:TW_LOG2] and col=c[TW_LOG2-1:0], yaddr={row[0],row[TW_LOG2-1:1],col[0],col[TW_LOG2-1:1]}. This groups each Bayer plane into one quadrant.
- Data, with B=2^(DW-1) and all arithmetic in DW+2 bits, result fits DW+1:
  - mono/jp4: y_out = pixel - B, registered (1-cycle pipeline).
  - jp4diff, per 2x2 cell, position p, reference pixel P_R:
    - p==R: pixel - B.
    - p==R^3 and hdr: pixel - B.
    - otherwise: pixel - P_R; if scale_diff, arithmetic >>1 (floor).
  - The reference comes from an internal delay line of TW+1 pixels (SRL-inferable) plus 2 taps; no external memory.
- Back-to-back: next pre_first_in is allowed at t0+N. With an unchanged context, output is contiguous with no gap (2N consecutive ywe).
- Context change on a pipelined next start: the new delayed start clears c and truncates the older tile.
- Simultaneous: a delayed start on the same cycle as the last ywe of the old tile means the new tile wins. Counter wrap at N-1 ends the tile; there is no modulo restart.
- pre_first_in while en=0 is ignored.

Test Plan:
1. mono, DW=8, TW_LOG2=4, din=k (ramp) -> ywe high t0+2..t0+257; yaddr 0..255; y_out(k=0)=0x180 (-128); y_out(k=255)=0x07F.
2. jp4 ramp -> c=1 gives yaddr 0x08; c=16 gives 0x80; c=17 gives 0x88; c=255 gives 0xFF; each address written exactly once.
3. jp4diff R=0, cells P0=100 P1=120 P2=90 P3=110, hdr=0, scale=0 -> -28, +20, -10, +10.
   - hdr=1: pos3 = -18.
   - scale_diff=1: pos1 +10, pos2 -5.
4. jp4diff R=3 -> pre_first_out at t0+21, first ywe at t0+22, ywe high 256 cycles, busy falls after t0+277.
5. Extremes, DW=8, jp4diff, P_R=0, other=255 -> +255 (0x0FF). P_R=255, other=0 -> -255 (0x101). With scale_diff -> 0x07F and 0x180.
6. Abort and pipelining:
   - en drop at pixel 100 -> next cycle ywe=0, yaddr=0, busy=0.
   - rst mid-tile -> same.
   - two back-to-back jp4 tiles -> 512 contiguous ywe.
   - second start with a mode change -> first tile truncated at the new delayed start.
